instr_cache: RTL and testbench
==============================

INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 Parameter: SETS, default 64, number of direct-mapped lines; power of two, at least 2.
REQ-002 Parameter: LINE_WORDS, default 4, 32-bit words per line; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 PCF  input  32  fetch byte address from the core.
REQ-006 Invalidate  input  1  one-cycle pulse requesting that all lines be invalidated.
REQ-007 InstrF  output  32  instruction word returned to the core.
REQ-008 InstrMissF  output  1  high when InstrF is not valid for the current PCF.
REQ-009 InstrCacheRepActive  output  1  high while a line refill is in progress.
REQ-010 MemReqValid  output  1  refill request to backing memory.
REQ-011 MemReqAddr  output  32  line-aligned refill byte address.
REQ-012 MemReqReady  input  1  backing memory accepts the request.
REQ-013 MemRespValid  input  1  one refill data beat is present.
REQ-014 MemRespData  input  32  refill data word, delivered in ascending word order.

Function
REQ-015 Address split (defaults shown): byte offset PCF[1:0] is ignored; word offset PCF[3:2]; index PCF[9:4]; tag PCF[31:10]. Field widths SHALL scale with SETS and LINE_WORDS.
REQ-016 Storage SHALL be: one valid bit, one tag and LINE_WORDS data words per set.
REQ-017 FSM states SHALL be IDLE, REQ and FILL.
REQ-018 IDLE: hit = valid[index] AND (tag[index] == PCF tag), evaluated combinationally in the same cycle.
REQ-019 IDLE hit: InstrF = data[index][word offset] in the same cycle; InstrMissF = 0.
REQ-020 IDLE miss: InstrMissF = 1; MemReqAddr is latched to {PCF[31:4], 4'b0}; next state is REQ.
REQ-021 REQ: MemReqValid = 1 with MemReqAddr held stable. On MemReqReady = 1, next state is FILL and the beat counter is set to 0.
REQ-022 FILL, per beat: each cycle with MemRespValid = 1 writes MemRespData to data[latched index][counter] and increments the counter.
REQ-023 FILL, final beat (counter = LINE_WORDS-1 with MemRespValid = 1): write the tag, set valid, and go to IDLE. The next cycle re-evaluates the current PCF.
REQ-024 MemRespValid SHALL be ignored outside FILL. MemReqReady SHALL be ignored outside REQ.
REQ-025 InstrMissF SHALL be 1 whenever state is not IDLE.
REQ-026 InstrCacheRepActive SHALL be 1 exactly in REQ and FILL.
REQ-027 InstrF SHALL be 32'h0000_0013 (NOP) whenever InstrMissF = 1.
REQ-028 If PCF changes during REQ or FILL, the latched refill completes unchanged; the lookup after refill uses the new PCF.
REQ-029 Invalidate in IDLE: all valid bits are cleared on that edge, taking effect the following cycle.
REQ-030 Invalidate during REQ or FILL: a pending flag is set. At refill completion all valid bits are cleared and the filled line is not validated; the pending flag is cleared.
REQ-031 Invalidate on the final-beat cycle SHALL behave as in REQ-030.
REQ-032 Miss-to-hit latency with zero-wait memory SHALL be 2 + LINE_WORDS cycles: 1 cycle IDLE miss, 1 cycle REQ, LINE_WORDS cycles FILL.

Reset
REQ-033 While reset = 0, the block SHALL hold: state IDLE, all valid bits 0, counter 0, pending-invalidate 0, MemReqValid 0, MemReqAddr 0, InstrCacheRepActive 0, InstrMissF 1, InstrF = 32'h0000_0013.
REQ-034 Tag and data arrays need no reset.
REQ-035 Reset asserted in REQ or FILL SHALL abort the refill; no line is validated.
REQ-036 The first fetch after reset deassertion SHALL miss.

Verification
REQ-037 Cold miss: after reset, PCF = 0x0000_0100, MemReqReady = 1, responses 0xA0..0xA3 one per cycle -> MemReqAddr = 0x100; InstrMissF high for 6 cycles; then InstrF = 0xA0 with InstrMissF = 0.
REQ-038 Hit after fill: PCF steps 0x104, 0x108, 0x10C -> InstrF = 0xA1, 0xA2, 0xA3 with no miss cycles and MemReqValid = 0.
REQ-039 Conflict: PCF = 0x0000_0500 (same index, different tag) -> refill occurs; afterwards PCF = 0x100 misses again.
REQ-040 Backpressure: MemReqReady is held 0 for 3 cycles and there are gaps between MemRespValid beats -> MemReqAddr is stable, the counter advances only on valid beats, and InstrCacheRepActive is high throughout.
REQ-041 Invalidate mid-FILL at beat 2 -> refill completes; PCF = 0x100 then misses; a previously valid line also misses.
REQ-042 Reset asserted during FILL beat 1 -> outputs take reset values immediately; after release, PCF = 0x100 misses and MemReqAddr = 0x100.

Source files
------------

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache with one outstanding line refill.
// Hits return in the lookup cycle; a miss refills the whole line in ascending word order.
module instr_cache #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        Invalidate,
  output logic [31:0] InstrF,
  output logic        InstrMissF,
  output logic        InstrCacheRepActive,
  output logic        MemReqValid,
  output logic [31:0] MemReqAddr,
  input  logic        MemReqReady,
  input  logic        MemRespValid,
  input  logic [31:0] MemRespData
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int IDX_LO   = 2 + OFF_BITS;
  localparam int TAG_LO   = IDX_LO + IDX_BITS;
  localparam int TAG_BITS = 32 - TAG_LO;

  localparam logic [31:0]         NOP       = 32'h0000_0013;
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  logic [1:0]          state;
  logic [SETS-1:0]     validBits;
  logic [TAG_BITS-1:0] tagArr  [SETS];
  logic [31:0]         dataArr [SETS][LINE_WORDS];
  logic [OFF_BITS-1:0] beatCnt;
  logic                invPending;

  logic [OFF_BITS-1:0] pcWord;
  logic [IDX_BITS-1:0] pcIdx;
  logic [TAG_BITS-1:0] pcTag;
  logic [IDX_BITS-1:0] fillIdx;
  logic [TAG_BITS-1:0] fillTag;
  logic                hit;
  logic                unusedBits;

  assign pcWord  = PCF[IDX_LO-1:2];
  assign pcIdx   = PCF[TAG_LO-1:IDX_LO];
  assign pcTag   = PCF[31:TAG_LO];
  // The refill target is taken from the latched request so PCF may move freely meanwhile.
  assign fillIdx = MemReqAddr[TAG_LO-1:IDX_LO];
  assign fillTag = MemReqAddr[31:TAG_LO];
  assign unusedBits = ^{PCF[1:0], MemReqAddr[IDX_LO-1:0]};

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    hit    = 1'b0;
    InstrF = NOP;
    if (state == IDLE && validBits[pcIdx] && tagArr[pcIdx] == pcTag) begin
      hit    = 1'b1;
      InstrF = dataArr[pcIdx][pcWord];
    end
  end

  assign InstrMissF          = ~hit;
  assign MemReqValid         = (state == REQ);
  assign InstrCacheRepActive = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only; later ones in the block win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      validBits  <= '0;
      beatCnt    <= '0;
      invPending <= 1'b0;
      MemReqAddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Invalidate) validBits <= '0;
          if (!hit) begin
            MemReqAddr <= {PCF[31:IDX_LO], {IDX_LO{1'b0}}};
            state      <= REQ;
          end
        end
        REQ: begin
          if (Invalidate) invPending <= 1'b1;
          if (MemReqReady) begin
            state   <= FILL;
            beatCnt <= '0;
          end
        end
        FILL: begin
          if (Invalidate) invPending <= 1'b1;
          if (MemRespValid) begin
            beatCnt <= beatCnt + OFF_BITS'(1);
            if (beatCnt == LAST_BEAT) begin
              state      <= IDLE;
              invPending <= 1'b0;
              // An invalidate seen during the refill wins over validating the new line.
              if (invPending || Invalidate) validBits <= '0;
              else validBits[fillIdx] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; validBits alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (state == FILL && MemRespValid) begin
      dataArr[fillIdx][beatCnt] <= MemRespData;
      if (beatCnt == LAST_BEAT) tagArr[fillIdx] <= fillTag;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: scoreboard bench for instr_cache with a behavioural refill memory
// that supports request backpressure and gaps between response beats.
module tb_instr_cache;

  localparam int SETS       = 64;
  localparam int LINE_WORDS = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic        Invalidate;
  logic [31:0] InstrF;
  logic        InstrMissF;
  logic        InstrCacheRepActive;
  logic        MemReqValid;
  logic [31:0] MemReqAddr;
  logic        MemReqReady;
  logic        MemRespValid;
  logic [31:0] MemRespData;

  int checkCount = 0;
  int passCount  = 0;
  logic [31:0] expQ[$];

  int readyDelay = 0;
  bit gapEn      = 0;

  int          lastMiss;
  int          lastRep;
  logic [31:0] lastReqAddr;
  bit          lastStable;
  bit          lastNopOk;
  logic        lastReqAtHit;

  instr_cache #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk                 (clk),
    .reset               (reset),
    .PCF                 (PCF),
    .Invalidate          (Invalidate),
    .InstrF              (InstrF),
    .InstrMissF          (InstrMissF),
    .InstrCacheRepActive (InstrCacheRepActive),
    .MemReqValid         (MemReqValid),
    .MemReqAddr          (MemReqAddr),
    .MemReqReady         (MemReqReady),
    .MemRespValid        (MemRespValid),
    .MemRespData         (MemRespData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expVal);
    checkCount++;
    if (got === expVal) passCount++;
    else $display("FAIL %s: got %h, expected %h", tag, got, expVal);
  endtask

  // Backing-store contents: line 0x100 holds 0xA0..0xA3, everything else is address-derived.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a[31:4] == 28'h000_0010) return 32'hA0 + 32'(a[3:2]);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Refill memory: drives inputs #1 after each rising edge.
  initial begin : responder
    logic [31:0] fillAddr;
    int beat;
    int waitCnt;
    bit filling;
    bit gapNow;
    fillAddr = '0;
    beat = 0;
    waitCnt = 0;
    filling = 1'b0;
    gapNow = 1'b0;
    MemReqReady  = 1'b0;
    MemRespValid = 1'b0;
    MemRespData  = '0;
    forever begin
      @(posedge clk);
      #1;
      MemReqReady  = 1'b0;
      MemRespValid = 1'b0;
      if (!reset) begin
        filling = 1'b0;
        waitCnt = 0;
      end else if (filling) begin
        if (gapNow) gapNow = 1'b0;
        else begin
          MemRespValid = 1'b1;
          MemRespData  = memWord(fillAddr + 32'(beat * 4));
          beat++;
          gapNow = gapEn;
          if (beat == LINE_WORDS) filling = 1'b0;
        end
      end else if (MemReqValid) begin
        if (waitCnt < readyDelay) waitCnt++;
        else begin
          MemReqReady = 1'b1;
          fillAddr = MemReqAddr;
          filling = 1'b1;
          beat = 0;
          waitCnt = 0;
          gapNow = 1'b0;
        end
      end
    end
  end

  // Samples on falling edges until a hit, then pops and compares the expected word.
  task automatic waitHit(input string tag);
    bit reqSeen;
    bit timedOut;
    logic [31:0] expVal;
    lastMiss = 0;
    lastRep = 0;
    lastReqAddr = '0;
    lastStable = 1'b1;
    lastNopOk = 1'b1;
    reqSeen = 1'b0;
    timedOut = 1'b0;
    forever begin
      @(negedge clk);
      if (!InstrMissF) begin
        lastReqAtHit = MemReqValid;
        break;
      end
      lastMiss++;
      if (InstrF !== NOP) lastNopOk = 1'b0;
      if (InstrCacheRepActive) lastRep++;
      if (MemReqValid) begin
        if (!reqSeen) begin
          reqSeen = 1'b1;
          lastReqAddr = MemReqAddr;
        end else if (MemReqAddr !== lastReqAddr) lastStable = 1'b0;
      end
      if (lastMiss >= 500) begin
        timedOut = 1'b1;
        break;
      end
    end
    if (timedOut) check({tag, "_timeout"}, 32'(timedOut), 32'd0);
    expVal = expQ.pop_front();
    check({tag, "_data"}, InstrF, expVal);
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr);
    @(posedge clk);
    #1;
    PCF = addr;
    Invalidate = 1'b0;
    expQ.push_back(memWord(addr));
    waitHit(tag);
  endtask

  task automatic fetchExpect(input string tag, input logic [31:0] addr, input int expMiss);
    fetch(tag, addr);
    check({tag, "_missCycles"}, 32'(lastMiss), 32'(expMiss));
  endtask

  task automatic waitReq(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!MemReqValid && n < 50);
    if (!MemReqValid) check({tag, "_reqTimeout"}, 32'(MemReqValid), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    PCF = 32'h100;
    Invalidate = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_missF", 32'(InstrMissF), 32'd1);
    check("rst_instr", InstrF, NOP);
    check("rst_reqValid", 32'(MemReqValid), 32'd0);
    check("rst_reqAddr", MemReqAddr, 32'd0);
    check("rst_repActive", 32'(InstrCacheRepActive), 32'd0);

    // Cold miss straight out of reset with zero-wait memory.
    @(posedge clk);
    #1 reset = 1'b1;
    expQ.push_back(memWord(32'h100));
    waitHit("cold");
    check("cold_missCycles", 32'(lastMiss), 32'(2 + LINE_WORDS));
    check("cold_reqAddr", lastReqAddr, 32'h100);
    check("cold_repActive", 32'(lastRep), 32'(1 + LINE_WORDS));
    check("cold_nopWhileMiss", 32'(lastNopOk), 32'd1);

    for (int i = 1; i < LINE_WORDS; i++) begin
      fetchExpect($sformatf("hit%0d", i), 32'h100 + 32'(i * 4), 0);
      check($sformatf("hit%0d_reqValid", i), 32'(lastReqAtHit), 32'd0);
    end

    // Same index, different tag evicts the line.
    fetchExpect("conflict", 32'h500, 6);
    check("conflict_reqAddr", lastReqAddr, 32'h500);
    fetchExpect("refetch100", 32'h100, 6);
    check("refetch100_reqAddr", lastReqAddr, 32'h100);
    fetchExpect("fill200", 32'h200, 6);
    fetchExpect("fill300", 32'h300, 6);
    fetchExpect("hit200", 32'h200, 0);

    // Invalidate on beat 2 of a refill, with PCF moving to a previously valid line.
    @(posedge clk);
    #1 PCF = 32'h440;
    waitReq("inv");
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    Invalidate = 1'b1;
    PCF = 32'h200;
    expQ.push_back(memWord(32'h200));
    @(posedge clk);
    #1 Invalidate = 1'b0;
    waitHit("inv");
    check("inv_missCycles", 32'(lastMiss), 32'd7);
    check("inv_reqAddr", lastReqAddr, 32'h200);
    fetchExpect("inv_100", 32'h100, 6);
    fetchExpect("inv_300", 32'h300, 6);
    fetchExpect("inv_440", 32'h440, 6);

    // Invalidate while idle takes effect on the following cycle.
    fetchExpect("idle_hit300", 32'h300, 0);
    Invalidate = 1'b1;
    fetchExpect("idleInv_300", 32'h300, 6);

    // Backpressure: 3 cycles without ready, then beats with one-cycle gaps.
    readyDelay = 3;
    gapEn = 1'b1;
    fetchExpect("bp", 32'h800, 12);
    check("bp_reqAddr", lastReqAddr, 32'h800);
    check("bp_addrStable", 32'(lastStable), 32'd1);
    check("bp_repActive", 32'(lastRep), 32'd11);
    readyDelay = 0;
    gapEn = 1'b0;
    for (int i = 1; i < LINE_WORDS; i++)
      fetchExpect($sformatf("bpHit%0d", i), 32'h800 + 32'(i * 4), 0);

    // Reset in the middle of a refill (beat 1).
    @(posedge clk);
    #1 PCF = 32'h400;
    waitReq("rstFill");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    check("rstFill_missF", 32'(InstrMissF), 32'd1);
    check("rstFill_instr", InstrF, NOP);
    check("rstFill_reqValid", 32'(MemReqValid), 32'd0);
    check("rstFill_reqAddr", MemReqAddr, 32'd0);
    check("rstFill_repActive", 32'(InstrCacheRepActive), 32'd0);
    PCF = 32'h100;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    expQ.push_back(memWord(32'h100));
    waitHit("postRst");
    check("postRst_missCycles", 32'(lastMiss), 32'd6);
    check("postRst_reqAddr", lastReqAddr, 32'h100);
    fetchExpect("postRst_400", 32'h400, 6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1);
  end

endmodule
